fir4_avg_outbuf: RTL and testbench

FIR4_AVG_OUTBUF -- requirements
Module: fir4_avg_outbuf

---
 rtl/fir4_avg_outbuf.sv | 146 ++++++++++++++
 tb/tb_fir4_avg_outbuf.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir4_avg_outbuf.sv
// fir4_avg_outbuf: divides a 4-tap FIR sum by four, registers it in one stage
// and queues it in a small output FIFO with valid/ready handshake.
//   clk          - single clock, rising edge
//   reset        - asynchronous, active-low reset
//   in_sum       - W+2 bit 4-tap sum from upstream; in_valid marks a new sample
//   out_data     - averaged sample at the FIFO head; out_valid while non-empty
//   out_ready    - consumer accepts out_data this cycle
//   count        - FIFO occupancy (0..DEPTH)
//   overflow     - sticky flag, set when a sample is dropped on a full FIFO
//   overflow_clr - synchronous clear of overflow (a same-edge drop wins)
// Build option: define FIR4_AVG_ROUND_EN for round-half-up averaging;
// without it the average truncates.
module fir4_avg_outbuf #(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [W+1:0]             in_sum,
  input  logic                     in_valid,
  output logic [W-1:0]             out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = W + 3;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } occ_e;

  // Divide-by-four of the incoming sum
  logic [W-1:0] avg;
  logic         unused_bits;

`ifdef FIR4_AVG_ROUND_EN
  logic [SW-1:0] sum_rnd;
  assign sum_rnd     = SW'(in_sum) + SW'(2);
  assign avg         = sum_rnd[W+1:2];
  assign unused_bits = ^{sum_rnd[SW-1], sum_rnd[1:0]};
`else
  assign avg         = in_sum[W+1:2];
  assign unused_bits = ^in_sum[1:0];
`endif

  // Stage register and FIFO storage
  logic          s1_valid;
  logic [W-1:0]  s1_data;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  occ_e          state;

  // Next-state signals
  occ_e          state_nxt;
  logic [CW-1:0] count_nxt;
  logic          overflow_nxt;
  logic          out_valid_nxt;
  logic          pop;
  logic          push_acc;
  logic          drop;

  // Occupancy control: a push into a full FIFO survives only alongside a pop
  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    overflow_nxt  = overflow;
    out_valid_nxt = out_valid;
    pop           = out_valid & out_ready;
    push_acc      = 1'b0;
    drop          = 1'b0;

    if (s1_valid) begin
      if ((state == ST_FULL) && !pop) begin
        drop = 1'b1;
      end else begin
        push_acc = 1'b1;
      end
    end

    count_nxt = count + CW'(push_acc) - CW'(pop);

    if (count_nxt == '0) begin
      state_nxt = ST_EMPTY;
    end else if (count_nxt == CW'(DEPTH)) begin
      state_nxt = ST_FULL;
    end else begin
      state_nxt = ST_PARTIAL;
    end

    out_valid_nxt = (count_nxt != '0);

    if (drop) begin
      overflow_nxt = 1'b1;
    end else if (overflow_clr) begin
      overflow_nxt = 1'b0;
    end
  end

  // Control and stage registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      state     <= ST_EMPTY;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      s1_valid  <= in_valid;
      if (in_valid) begin
        s1_data <= avg;
      end
      state     <= state_nxt;
      count     <= count_nxt;
      out_valid <= out_valid_nxt;
      overflow  <= overflow_nxt;
      // Power-of-two depth makes the natural pointer wrap the modulo
      if (push_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  // FIFO array, not reset; stale entries are unreachable once pointers clear
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= s1_data;
    end
  end

  assign out_data = mem[rd_ptr];

endmodule

// File: tb/tb_fir4_avg_outbuf.sv
// Bench for fir4_avg_outbuf: directed cases plus random traffic, checked
// against a queue-based reference model each cycle.
module tb_fir4_avg_outbuf;

  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 4;

  logic          clk;
  logic          reset;
  logic [W+1:0]  in_sum;
  logic          in_valid;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    count;
  logic          overflow;
  logic          overflow_clr;

  int checks;
  int errors;

  // Reference model state
  logic [W-1:0] q[$];
  logic         m_s1v;
  logic [W-1:0] m_s1d;
  logic         m_ovf;

  fir4_avg_outbuf #(.W(W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_sum       (in_sum),
    .in_valid     (in_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .count        (count),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_avg(input logic [W+1:0] s);
    int t;
    t = int'(s);
`ifdef FIR4_AVG_ROUND_EN
    t = (t + 2) / 4;
`else
    t = t / 4;
`endif
    return W'(t);
  endfunction

  task automatic model_reset();
    q.delete();
    m_s1v = 1'b0;
    m_s1d = '0;
    m_ovf = 1'b0;
  endtask

  // Advance one clock edge in model and DUT, then compare all outputs
  task automatic step();
    logic pop;
    logic drop;
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
      pop  = (q.size() > 0) && out_ready;
      drop = m_s1v && (q.size() == DEPTH) && !pop;
      if (pop) void'(q.pop_front());
      if (m_s1v && !drop) q.push_back(m_s1d);
      if (drop) m_ovf = 1'b1;
      else if (overflow_clr) m_ovf = 1'b0;
      m_s1v = in_valid;
      if (in_valid) m_s1d = ref_avg(in_sum);
    end
    #1;
    check_val("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check_val("count", 32'(count), 32'(q.size()));
    if (q.size() > 0) check_val("out_data", 32'(out_data), 32'(q[0]));
    check_val("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 3; i++) step();
  endtask

  initial begin
    logic [W-1:0] exp_pop [4];
    checks = 0;
    errors = 0;
    reset = 1'b0;
    in_sum = '0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    overflow_clr = 1'b0;
    model_reset();

    // Reset state
    #12;
    check_val("rst_valid", 32'(out_valid), 32'd0);
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_ovf", 32'(overflow), 32'd0);
    step();
    reset = 1'b1;

    // Maximum sum, two-cycle latency
    in_sum = 18'h3FFFC;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check_val("lat_not_yet", 32'(out_valid), 32'd0);
    step();
    check_val("max_valid", 32'(out_valid), 32'd1);
    check_val("max_data", 32'(out_data), 32'hFFFF);
    step();

    // Rounding versus truncation
    in_sum = 18'd6;
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    step();
`ifdef FIR4_AVG_ROUND_EN
    check_val("six", 32'(out_data), 32'd2);
`else
    check_val("six", 32'(out_data), 32'd1);
`endif
    drain();

    // Fill past full with no consumer
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_sum = 18'(i * 40);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    check_val("full_count", 32'(count), 32'd4);
    check_val("full_ovf", 32'(overflow), 32'd1);

    // Clear request loses to a same-edge drop, then takes effect
    in_sum = 18'd240;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    overflow_clr = 1'b1;
    step();
    check_val("clr_drop", 32'(overflow), 32'd1);
    step();
    check_val("clr_nodrop", 32'(overflow), 32'd0);
    overflow_clr = 1'b0;

    exp_pop[0] = 16'd10;
    exp_pop[1] = 16'd20;
    exp_pop[2] = 16'd30;
    exp_pop[3] = 16'd40;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_val("pop_order", 32'(out_data), 32'(exp_pop[i]));
      step();
    end
    check_val("pop_empty", 32'(out_valid), 32'd0);

    // Full FIFO with a streaming consumer holds at DEPTH without drops
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_sum = 18'((i + 1) * 400);
      in_valid = 1'b1;
      step();
    end
    out_ready = 1'b1;
    for (int i = 5; i < 13; i++) begin
      in_sum = 18'((i + 1) * 400);
      step();
      check_val("stream_count", 32'(count), 32'd4);
      check_val("stream_ovf", 32'(overflow), 32'd0);
    end
    drain();

    // Asynchronous reset mid-cycle with three entries queued
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_sum = 18'($urandom);
      step();
    end
    in_valid = 1'b0;
    step();
    check_val("pre_rst_count", 32'(count), 32'd3);
    #2;
    reset = 1'b0;
    #1;
    check_val("async_valid", 32'(out_valid), 32'd0);
    check_val("async_count", 32'(count), 32'd0);
    check_val("async_ovf", 32'(overflow), 32'd0);
    model_reset();
    step();
    reset = 1'b1;
    step();
    check_val("post_rst_count", 32'(count), 32'd0);

    // Random traffic: slow consumer first, then a faster one
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(3, 0) != 0);
      in_sum = 18'($urandom);
      out_ready = (i < 300) ? ($urandom_range(3, 0) == 0) : ($urandom_range(3, 0) != 0);
      overflow_clr = ($urandom_range(15, 0) == 0);
      step();
    end
    overflow_clr = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
